temp_stats_display: RTL and testbench

//  Statistics/mode stage between the I2C temperature controller (or the switch test

---
 rtl/temp_disp_pkg.sv | 20 ++
 rtl/temp_avg_window.sv | 55 +++++
 rtl/temp_stats_display.sv | 117 +++++++++++
 tb/tb_temp_stats_display.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/temp_disp_pkg.sv
// Shared display-mode type and mode sequencing for the temperature display path.
package temp_disp_pkg;

  typedef enum logic [1:0] {
    CUR = 2'd0,
    MIN = 2'd1,
    MAX = 2'd2,
    AVG = 2'd3
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      CUR:     next_mode = MIN;
      MIN:     next_mode = MAX;
      MAX:     next_mode = AVG;
      default: next_mode = CUR;
    endcase
  endfunction

endpackage

// File: rtl/temp_avg_window.sv
// Moving-average window: sample RAM, write pointer and running sum.
// avg is the next-state average, i.e. it already includes a sample accepted this cycle.
module temp_avg_window
  import temp_disp_pkg::*;
#(
  parameter int W        = 13,
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                acc,
  input  logic                seed,
  input  logic signed [W-1:0] src,
  output logic signed [W-1:0] avg
);

  localparam int DEPTH = 1 << AVG_LOG2;
  localparam int SW    = W + AVG_LOG2;

  logic signed [W-1:0]  win_p0 [DEPTH];
  logic [AVG_LOG2-1:0]  wp_p0;
  logic signed [SW-1:0] sum_p0;
  logic signed [SW-1:0] sum_nxt;
  logic signed [SW-1:0] src_ext;

  always_comb begin
    src_ext = SW'(src);
    sum_nxt = sum_p0;
    if (acc) begin
      // Seeding fills every slot with src, so the sum is src scaled by the depth.
      if (seed) sum_nxt = src_ext <<< AVG_LOG2;
      else      sum_nxt = sum_p0 + src_ext - SW'(win_p0[wp_p0]);
    end
    avg = W'(sum_nxt >>> AVG_LOG2);
  end

  // Stage p0: window contents, pointer and running sum
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_p0 <= '0;
      wp_p0  <= '0;
      for (int i = 0; i < DEPTH; i++) win_p0[i] <= '0;
    end else if (acc) begin
      sum_p0 <= sum_nxt;
      if (seed) begin
        wp_p0 <= '0;
        for (int i = 0; i < DEPTH; i++) win_p0[i] <= src;
      end else begin
        win_p0[wp_p0] <= src;
        wp_p0         <= wp_p0 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/temp_stats_display.sv
// Temperature statistics stage: current/min/max/moving-average with a display-mode
// selector, registered display value and a stale-data timeout.
module temp_stats_display
  import temp_disp_pkg::*;
#(
  parameter int W              = 13,
  parameter int FRAC_BITS      = 4,
  parameter int AVG_LOG2       = 3,
  parameter int TIMEOUT_CYCLES = 100000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_valid,
  input  logic signed [W-1:0] sample,
  input  logic                test_enb,
  input  logic                test_stb,
  input  logic signed [W-1:0] test_val,
  input  logic                mode_btn,
  input  logic                clr_minmax,
  output logic signed [W-1:0] disp_val,
  output mode_t               disp_mode,
  output logic                disp_valid,
  output logic                stale
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

  if (AVG_LOG2 < 1 || AVG_LOG2 > 6 || FRAC_BITS >= W) begin : g_bad_param
    $error("temp_stats_display: unsupported AVG_LOG2/FRAC_BITS");
  end

  logic                acc;
  logic signed [W-1:0] src;
  logic signed [W-1:0] avg;
  logic                seeded_p0;
  logic signed [W-1:0] cur_p0, min_p0, max_p0;
  logic signed [W-1:0] cur_nxt, min_nxt, max_nxt, sel, disp_nxt;
  mode_t               mode_p0, mode_nxt;
  logic [CW-1:0]       cnt_p0, cnt_nxt;

  temp_avg_window #(
    .W        (W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_avg (
    .clk  (clk),
    .rst  (rst),
    .acc  (acc),
    .seed (!seeded_p0),
    .src  (src),
    .avg  (avg)
  );

  always_comb begin
    acc     = test_enb ? test_stb : sample_valid;
    src     = test_enb ? test_val : sample;
    cur_nxt = cur_p0;
    min_nxt = min_p0;
    max_nxt = max_p0;
    if (acc) begin
      cur_nxt = src;
      if (!seeded_p0 || clr_minmax) begin
        min_nxt = src;
        max_nxt = src;
      end else begin
        if (src < min_p0) min_nxt = src;
        if (src > max_p0) max_nxt = src;
      end
    end else if (clr_minmax && seeded_p0) begin
      min_nxt = cur_p0;
      max_nxt = cur_p0;
    end

    mode_nxt = mode_btn ? next_mode(mode_p0) : mode_p0;
    sel      = cur_nxt;
    case (mode_nxt)
      MIN:     sel = min_nxt;
      MAX:     sel = max_nxt;
      AVG:     sel = avg;
      default: sel = cur_nxt;
    endcase
    disp_nxt = (seeded_p0 || acc) ? sel : '0;

    // Saturating idle counter; any accepted sample restarts it.
    if (acc)                cnt_nxt = '0;
    else if (cnt_p0 >= TMAX) cnt_nxt = cnt_p0;
    else                    cnt_nxt = cnt_p0 + 1'b1;
  end

  // Stage p0: statistics, mode, timeout; display register follows from next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      seeded_p0  <= 1'b0;
      cur_p0     <= '0;
      min_p0     <= '0;
      max_p0     <= '0;
      mode_p0    <= CUR;
      cnt_p0     <= '0;
      stale      <= 1'b0;
      disp_val   <= '0;
      disp_valid <= 1'b0;
    end else begin
      seeded_p0  <= seeded_p0 | acc;
      cur_p0     <= cur_nxt;
      min_p0     <= min_nxt;
      max_p0     <= max_nxt;
      mode_p0    <= mode_nxt;
      cnt_p0     <= cnt_nxt;
      stale      <= (cnt_nxt >= TMAX);
      disp_val   <= disp_nxt;
      disp_valid <= seeded_p0 | acc;
    end
  end

  assign disp_mode = mode_p0;

endmodule

// File: tb/tb_temp_stats_display.sv
// Directed bench for temp_stats_display: vector table plus timeout and reset sequences.
module tb_temp_stats_display;

  logic        clk = 1'b0;
  logic        rst, sample_valid, test_enb, test_stb, mode_btn, clr_minmax;
  logic [12:0] sample, test_val;
  logic [12:0] disp_val;
  logic [1:0]  disp_mode;
  logic        disp_valid, stale;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  temp_stats_display #(
    .W              (13),
    .FRAC_BITS      (4),
    .AVG_LOG2       (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .test_enb     (test_enb),
    .test_stb     (test_stb),
    .test_val     (test_val),
    .mode_btn     (mode_btn),
    .clr_minmax   (clr_minmax),
    .disp_val     (disp_val),
    .disp_mode    (disp_mode),
    .disp_valid   (disp_valid),
    .stale        (stale)
  );

  typedef struct {
    logic        rst;
    logic        tenb;
    logic        sv;
    logic [12:0] s;
    logic        ts;
    logic [12:0] tv;
    logic        btn;
    logic        clr;
    logic [12:0] ev;
    logic [1:0]  em;
    logic        evd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic tenb, input logic sv, input logic [12:0] s,
                     input logic ts, input logic [12:0] tv, input logic btn, input logic clr,
                     input logic [12:0] ev, input logic [1:0] em, input logic evd);
    vec_t v;
    v.rst = r; v.tenb = tenb; v.sv = sv; v.s = s; v.ts = ts; v.tv = tv;
    v.btn = btn; v.clr = clr; v.ev = ev; v.em = em; v.evd = evd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; sample_valid = 1'b0; sample = '0; test_enb = 1'b0;
    test_stb = 1'b0; test_val = '0; mode_btn = 1'b0; clr_minmax = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle_inputs();

    //   rst tenb sv  s         ts tv        btn clr  ev        em    evd
    add(1, 0, 0, 13'h0000, 0, 13'h0000, 0, 0, 13'h0000, 2'd0, 0);
    add(0, 0, 1, 13'h0190, 0, 13'h0000, 0, 0, 13'h0190, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0190, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0190, 2'd2, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0190, 2'd3, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0190, 2'd0, 1);
    add(0, 0, 1, 13'h0100, 0, 13'h0000, 0, 0, 13'h0100, 2'd0, 1);
    add(0, 0, 1, 13'h0200, 0, 13'h0000, 0, 0, 13'h0200, 2'd0, 1);
    add(0, 0, 1, 13'h1F80, 0, 13'h0000, 0, 0, 13'h1F80, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1F80, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0200, 2'd2, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h014A, 2'd3, 1);
    add(1, 0, 0, 13'h0000, 0, 13'h0000, 0, 0, 13'h0000, 2'd0, 0);
    add(0, 0, 1, 13'h0000, 0, 13'h0000, 0, 0, 13'h0000, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0000, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0000, 2'd2, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0000, 2'd3, 1);
    for (int k = 1; k <= 8; k++)
      add(0, 0, 1, 13'h0080, 0, 13'h0000, 0, 0, 13'(k * 16), 2'd3, 1);
    add(0, 0, 1, 13'h0000, 0, 13'h0000, 0, 0, 13'h0070, 2'd3, 1);
    add(0, 0, 1, 13'h1FFF, 0, 13'h0000, 0, 0, 13'h005F, 2'd3, 1);
    add(0, 0, 1, 13'h0050, 0, 13'h0000, 1, 1, 13'h0050, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0050, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0050, 2'd2, 1);
    add(0, 0, 1, 13'h1F00, 0, 13'h0000, 1, 0, 13'h0029, 2'd3, 1);
    add(0, 0, 1, 13'h1C00, 0, 13'h0000, 0, 0, 13'h1F99, 2'd3, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1C00, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 1, 13'h1C00, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1C00, 2'd2, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1F99, 2'd3, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1C00, 2'd0, 1);
    add(0, 1, 1, 13'h0100, 1, 13'h1E00, 0, 0, 13'h1E00, 2'd0, 1);
    add(0, 1, 1, 13'h0100, 0, 13'h0000, 0, 0, 13'h1E00, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 1, 13'h00AA, 0, 0, 13'h1E00, 2'd0, 1);
    add(0, 0, 1, 13'h0300, 0, 13'h0000, 0, 0, 13'h0300, 2'd0, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1C00, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0300, 2'd2, 1);
    add(1, 0, 0, 13'h0000, 0, 13'h0000, 0, 0, 13'h0000, 2'd0, 0);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h0000, 2'd1, 0);
    add(0, 0, 1, 13'h1FF0, 0, 13'h0000, 0, 0, 13'h1FF0, 2'd1, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1FF0, 2'd2, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1FF0, 2'd3, 1);
    add(0, 0, 0, 13'h0000, 0, 13'h0000, 1, 0, 13'h1FF0, 2'd0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; test_enb = tbl[i].tenb; sample_valid = tbl[i].sv;
      sample = tbl[i].s; test_stb = tbl[i].ts; test_val = tbl[i].tv;
      mode_btn = tbl[i].btn; clr_minmax = tbl[i].clr;
      step();
      chk($sformatf("row%0d disp_val", i), 32'(disp_val), 32'(tbl[i].ev));
      chk($sformatf("row%0d disp_mode", i), 32'(disp_mode), 32'(tbl[i].em));
      chk($sformatf("row%0d disp_valid", i), 32'(disp_valid), 32'(tbl[i].evd));
    end

    // Timeout: reset, one sample, then idle until stale, saturate, and recover.
    idle_inputs();
    rst = 1'b1;
    step();
    chk("reset stale", 32'(stale), 32'd0);
    chk("reset disp_valid", 32'(disp_valid), 32'd0);
    rst = 1'b0; sample_valid = 1'b1; sample = 13'h0123;
    step();
    idle_inputs();
    chk("to acc stale", 32'(stale), 32'd0);
    chk("to acc val", 32'(disp_val), 32'h0123);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("to idle%0d stale", k), 32'(stale), (k >= 16) ? 32'd1 : 32'd0);
    end
    chk("to stale val held", 32'(disp_val), 32'h0123);
    chk("to stale valid held", 32'(disp_valid), 32'd1);
    for (int k = 0; k < 5; k++) step();
    chk("to saturated stale", 32'(stale), 32'd1);
    sample_valid = 1'b1; sample = 13'h0045;
    step();
    idle_inputs();
    chk("to recover stale", 32'(stale), 32'd0);
    chk("to recover val", 32'(disp_val), 32'h0045);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("to again%0d stale", k), 32'(stale), (k >= 16) ? 32'd1 : 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
